// File: rtl/riscv_div_pkg.sv
// riscv_div_pkg
// Shared definitions for the RV32M iterative divider and the decoder that
// feeds it.
//   div_op_e : operation encoding, identical to funct3[1:0] of DIV/DIVU/REM/REMU
//   state_e  : divider sequencing states
package riscv_div_pkg;

   typedef enum logic [1:0] {
      DIV_S = 2'b00,
      DIV_U = 2'b01,
      REM_S = 2'b10,
      REM_U = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_e;

endpackage

// File: rtl/div_step.sv
// div_step
// One combinational restoring-division iteration.
// Ports:
//   rem      : current partial remainder (WIDTH+1 bits)
//   quo      : current quotient/dividend shift register
//   divisor  : divisor magnitude
//   rem_next : partial remainder after this iteration
//   quo_next : quotient register after this iteration (new bit in LSB)
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH+1:0] rem_shift;
   logic [WIDTH+1:0] trial;

   // Shift {rem, quo} left by one; one extra guard bit keeps the sign of
   // the trial subtraction exact.
   assign rem_shift = {rem, quo[WIDTH-1]};
   assign trial     = rem_shift - {2'b00, divisor};

   // Keep the subtraction only when it did not go negative.
   always_comb begin
      rem_next = rem_shift[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
      if (!trial[WIDTH+1]) begin
         rem_next    = trial[WIDTH:0];
         quo_next[0] = 1'b1;
      end
   end

endmodule

// File: rtl/iter_divider.sv
// iter_divider
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit
// per clock.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   start_valid   : request valid; start_ready high only when idle
//   op            : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend      : rs1, latched on accept
//   divisor       : rs2, latched on accept
//   result_valid  : result held; result_ready completes the handshake
//   result        : quotient or remainder (registered)
//   busy          : high whenever not idle
module iter_divider
   import riscv_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvsr;
   logic             neg_q;
   logic             neg_r;
   logic             want_rem;

   div_op_e          op_e;
   logic             is_signed;
   logic             op_rem;
   logic             div_zero;
   logic             overflow;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   assign start_ready  = (state == IDLE);
   assign result_valid = (state == DONE);
   assign busy         = (state != IDLE);

   // Decode the request and detect the cases answered without iterating.
   assign op_e      = div_op_e'(op);
   assign is_signed = (op_e == DIV_S) || (op_e == REM_S);
   assign op_rem    = (op_e == REM_S) || (op_e == REM_U);
   assign div_zero  = (divisor == '0);
   assign overflow  = is_signed && (dividend == MIN_NEG) && (divisor == '1);

   // The iteration works on magnitudes; MIN_NEG maps onto itself, which is
   // still the correct unsigned magnitude.
   assign mag_a = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
   assign mag_b = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

   // After WIDTH iterations the remainder fits in WIDTH bits.
   assign q_fix = neg_q ? -quo : quo;
   assign r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (dvsr),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   // Sequencer: IDLE accepts, CALC iterates WIDTH times, FIX applies signs,
   // DONE holds the result until the consumer takes it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dvsr     <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         want_rem <= 1'b0;
         result   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_valid) begin
                  cnt      <= '0;
                  rem      <= '0;
                  want_rem <= op_rem;
                  if (div_zero) begin
                     result <= op_rem ? dividend : '1;
                     state  <= DONE;
                  end else if (overflow) begin
                     result <= op_rem ? '0 : dividend;
                     state  <= DONE;
                  end else begin
                     quo   <= mag_a;
                     dvsr  <= mag_b;
                     neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                     neg_r <= is_signed && dividend[WIDTH-1];
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= rem_next;
               quo <= quo_next;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST_CNT) begin
                  state <= FIX;
               end
            end
            FIX: begin
               result <= want_rem ? r_fix : q_fix;
               state  <= DONE;
            end
            DONE: begin
               if (result_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
